uart_rx_ctrl: RTL and testbench

- Receive-side controller of the UART RX path. Sits alongside the bit-sampling stage.
- Generates the per-bit oversampling edge counter and the sampling enable that drive the sampler.
- Consumes the sampler's majority-voted `sampled_bit` and runs the frame FSM: start-glitch check, LSB-first deserialisation, optional parity check, stop check.
- Presents the received byte with a one-cycle valid strobe and sticky error flags.

---
 rtl/uart_rx_ctrl_if.sv | 26 ++
 rtl/uart_rx_ctrl.sv | 115 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Handshake bundle between the UART RX controller, the bit sampler side and the byte consumer.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  sampled_bit;
  logic [4:0]            edge_cnt;
  logic                  sample_en;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
    input  edge_cnt, sample_en, P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
    output edge_cnt, sample_en, P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: oversampling edge counter, sampler enable, and the
// start/data/parity/stop frame FSM producing a byte strobe with sticky error flags.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  localparam int unsigned EDGE_W = 5;
  localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  sample_en;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  end_of_bit;
  logic                  exp_par;

  assign end_of_bit = ({1'b0, edge_cnt} == (bus.Prescale - 6'd1));
  assign exp_par    = par_typ_q ? ~(^p_data) : (^p_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_data     <= '0;
      sample_en  <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // Edge counter runs only while a frame is in flight and wraps at each bit boundary.
      if (state == IDLE || end_of_bit) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end

      case (state)
        IDLE: begin
          if (!bus.RX_IN) begin
            state     <= START;
            sample_en <= 1'b1;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
          end
        end
        START: begin
          if (end_of_bit) begin
            if (!bus.sampled_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state     <= IDLE;
              sample_en <= 1'b0;
            end
          end
        end
        DATA: begin
          if (end_of_bit) begin
            // Line order is LSB first, so each new bit enters at the top.
            p_data  <= {bus.sampled_bit, p_data[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              state <= par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (end_of_bit) begin
            par_err <= (bus.sampled_bit != exp_par);
            state   <= STOP;
          end
        end
        STOP: begin
          if (end_of_bit) begin
            stp_err    <= ~bus.sampled_bit;
            data_valid <= bus.sampled_bit & ~par_err;
            sample_en  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          sample_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.edge_cnt   = edge_cnt;
  assign bus.sample_en  = sample_en;
  assign bus.P_DATA     = p_data;
  assign bus.data_valid = data_valid;
  assign bus.par_err    = par_err;
  assign bus.stp_err    = stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial line driver, mid-bit majority sampler and a
// frame-level reference model for data, flags, strobe count and latency.
module tb_uart_rx_ctrl;

  logic clk;
  logic rst;
  uart_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cur_p    = 8;

  int dv_cnt   = 0;
  int dv_cyc   = 0;
  int wraps    = 0;
  int viol     = 0;
  logic [7:0] dv_q[$];

  int   prev_edge = 0;
  logic prev_en   = 1'b0;
  logic [2:0] smp = 3'b111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Sampler stand-in: three line samples around mid-bit, majority voted.
  always @(posedge clk) begin
    if (bus.sample_en && int'(bus.edge_cnt) >= cur_p/2 - 1 && int'(bus.edge_cnt) <= cur_p/2 + 1)
      smp <= {smp[1:0], bus.RX_IN};
  end
  assign bus.sampled_bit = (smp[0] & smp[1]) | (smp[1] & smp[2]) | (smp[0] & smp[2]);

  // Observer: strobes, bit-boundary wraps and edge counter sequencing.
  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_q.push_back(bus.P_DATA);
    end
    if (prev_en && bus.sample_en) begin
      if (int'(bus.edge_cnt) != (prev_edge + 1) % cur_p) viol++;
      if (prev_edge == cur_p - 1 && bus.edge_cnt == 5'd0) wraps++;
    end
    if (!bus.sample_en && bus.edge_cnt != 5'd0) viol++;
    prev_edge = int'(bus.edge_cnt);
    prev_en   = bus.sample_en;
  end

  function automatic bit ref_par(input logic [7:0] d, input bit odd);
    int ones;
    ones = $countones(d);
    return odd ? bit'((ones + 1) % 2) : bit'(ones % 2);
  endfunction

  // Drives one frame starting now (caller is just after a rising edge).
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pb, input bit sb,
                            input bit scr);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back(pb);
    q.push_back(sb);
    for (int i = 0; i < q.size(); i++) begin
      bus.RX_IN = q[i];
      repeat (cur_p) @(posedge clk);
      #1;
      if (scr && i == 0) begin
        bus.PAR_EN  = ~bus.PAR_EN;
        bus.PAR_TYP = ~bus.PAR_TYP;
      end
    end
    bus.RX_IN = 1'b1;
  endtask

  task automatic clear_obs();
    dv_cnt = 0;
    wraps  = 0;
    viol   = 0;
    dv_q.delete();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit pe, input bit pt,
                           input bit pb, input bit sb, input bit scr);
    bit exp_perr;
    bit exp_serr;
    bit exp_dv;
    int t0;
    bus.PAR_EN  = pe;
    bus.PAR_TYP = pt;
    clear_obs();
    t0 = cyc;
    send_frame(d, pe, pb, sb, scr);
    repeat (3) @(posedge clk);
    #1;
    exp_perr = pe && (pb != ref_par(d, pt));
    exp_serr = !sb;
    exp_dv   = !exp_perr && !exp_serr;
    check({tag, "_dv_cnt"}, 32'(dv_cnt), 32'(exp_dv));
    check({tag, "_p_data"}, 32'(bus.P_DATA), 32'(d));
    check({tag, "_par_err"}, 32'(bus.par_err), 32'(exp_perr));
    check({tag, "_stp_err"}, 32'(bus.stp_err), 32'(exp_serr));
    check({tag, "_wraps"}, 32'(wraps), 32'(9 + int'(pe)));
    check({tag, "_edge_seq"}, 32'(viol), 32'd0);
    check({tag, "_idle_en"}, 32'(bus.sample_en), 32'd0);
    if (exp_dv) check({tag, "_latency"}, 32'(dv_cyc - t0), 32'((10 + int'(pe)) * cur_p + 1));
  endtask

  task automatic set_p(input int p);
    cur_p        = p;
    bus.Prescale = 6'(p);
  endtask

  initial begin
    logic [7:0] rd;
    bit rpe, rpt, rpb, rsb, rscr;
    int rp;

    rst         = 1'b0;
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    set_p(8);
    repeat (3) @(posedge clk);
    #1;
    check("rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    check("rst_sample_en", 32'(bus.sample_en), 32'd0);
    check("rst_p_data", 32'(bus.P_DATA), 32'd0);
    check("rst_dv", 32'(bus.data_valid), 32'd0);
    check("rst_par_err", 32'(bus.par_err), 32'd0);
    check("rst_stp_err", 32'(bus.stp_err), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    set_p(8);
    run_frame("f55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    set_p(16);
    run_frame("fa3_ok", 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("fa3_perr", 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    set_p(32);
    run_frame("f00_serr", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Short low pulse on the line must be rejected as a start glitch.
    set_p(8);
    clear_obs();
    bus.RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.RX_IN = 1'b1;
    check("glitch_en_high", 32'(bus.sample_en), 32'd1);
    repeat (cur_p + 2) @(posedge clk);
    #1;
    check("glitch_en_low", 32'(bus.sample_en), 32'd0);
    check("glitch_dv", 32'(dv_cnt), 32'd0);
    check("glitch_wraps", 32'(wraps), 32'd0);
    check("glitch_flags", 32'({bus.par_err, bus.stp_err}), 32'd0);
    check("glitch_edge", 32'(bus.edge_cnt), 32'd0);

    // Back-to-back frames with no idle bit between them.
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    clear_obs();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_cnt", 32'(dv_q.size()), 32'd2);
    check("b2b_first", (dv_q.size() > 0) ? 32'(dv_q[0]) : 32'hFFFF, 32'h3C);
    check("b2b_second", (dv_q.size() > 1) ? 32'(dv_q[1]) : 32'hFFFF, 32'hC3);
    check("b2b_wraps", 32'(wraps), 32'd18);

    // Asynchronous reset in the middle of the data bits of 0xFF.
    set_p(16);
    clear_obs();
    bus.RX_IN = 1'b0;
    repeat (cur_p) @(posedge clk);
    #1;
    bus.RX_IN = 1'b1;
    repeat (5 * cur_p) @(posedge clk);
    #3;
    check("mid_p_data_nz", 32'(bus.P_DATA != 8'h00), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    check("arst_sample_en", 32'(bus.sample_en), 32'd0);
    check("arst_p_data", 32'(bus.P_DATA), 32'd0);
    check("arst_flags", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_dv", 32'(dv_cnt), 32'd0);
    run_frame("f12", 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized frames, some with corrupted parity/stop and mid-frame config changes.
    for (int n = 0; n < 12; n++) begin
      rp   = 8 << $urandom_range(0, 2);
      rd   = 8'($urandom_range(0, 255));
      rpe  = bit'($urandom_range(0, 1));
      rpt  = bit'($urandom_range(0, 1));
      rpb  = ref_par(rd, rpt) ^ ($urandom_range(0, 3) == 0);
      rsb  = ($urandom_range(0, 4) != 0);
      rscr = bit'($urandom_range(0, 1));
      set_p(rp);
      run_frame($sformatf("rnd%0d", n), rd, rpe, rpt, rpb, rsb, rscr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
